// File: rtl/fish_rom_arbiter_if.sv
// Requester/ROM/response bundle for the shared fish sprite ROM arbiter.
// The master side owns the requesters and the ROM; the slave side is the arbiter.
interface fish_rom_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic                   en;
  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     req_row;
  logic [4*N_REQ-1:0]     req_col;
  logic [N_REQ-1:0]       gnt;
  logic [2:0]             rom_row;
  logic [3:0]             rom_col;
  logic [11:0]            rom_data;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [11:0]            rsp_color;
  logic                   rsp_opaque;

  modport master (
    output en, req, req_row, req_col, rom_data,
    input  gnt, rom_row, rom_col, rsp_valid, rsp_id, rsp_color, rsp_opaque
  );

  modport slave (
    input  en, req, req_row, req_col, rom_data,
    output gnt, rom_row, rom_col, rsp_valid, rsp_id, rsp_color, rsp_opaque
  );
endinterface

// File: rtl/fish_rom_arbiter.sv
// Round-robin arbiter sharing one registered-address 8x15 sprite ROM among
// N_REQ fish renderers; responses return two cycles after the grant.
module fish_rom_arbiter_lane (
  input  logic       gnt,
  input  logic [2:0] row,
  input  logic [3:0] col,
  output logic [2:0] row_m,
  output logic [3:0] col_m
);
  assign row_m = gnt ? row : '0;
  assign col_m = gnt ? col : '0;
endmodule

module fish_rom_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fish_rom_arbiter_if.slave bus
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int STAGES = 2;

  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [ID_W-1:0]          gnt_idx;
  logic                     gnt_any;
  logic [N_REQ-1:0]         gnt;
  int                       idx;

  logic [N_REQ-1:0][2:0]    row_m;
  logic [N_REQ-1:0][3:0]    col_m;
  logic [2:0]               rom_row;
  logic [3:0]               rom_col;

  logic [STAGES:1]          vld_pipe_q, vld_pipe_d;
  logic [ID_W-1:0]          s1_id_q, s1_id_d;
  logic                     s1_bad_q, s1_bad_d;
  logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
  logic [11:0]              rsp_color_q, rsp_color_d;
  logic                     rsp_opaque_q, rsp_opaque_d;
  logic [11:0]              color;

  // Search starts at ptr and wraps; reset also suppresses grants.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (rst_n && bus.en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    fish_rom_arbiter_lane u_lane (
      .gnt   (gnt[g]),
      .row   (bus.req_row[3*g +: 3]),
      .col   (bus.req_col[4*g +: 4]),
      .row_m (row_m[g]),
      .col_m (col_m[g])
    );
  end

  // One-hot grant makes the OR of masked lanes a mux.
  always_comb begin
    rom_row = '0;
    rom_col = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rom_row = rom_row | row_m[i];
      rom_col = rom_col | col_m[i];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);

    vld_pipe_d = {vld_pipe_q[STAGES-1:1], gnt_any};
    s1_id_d    = gnt_any ? gnt_idx : s1_id_q;
    s1_bad_d   = gnt_any ? (rom_col == 4'hF) : s1_bad_q;

    color        = s1_bad_q ? 12'h000 : bus.rom_data;
    rsp_id_d     = rsp_id_q;
    rsp_color_d  = rsp_color_q;
    rsp_opaque_d = rsp_opaque_q;
    if (vld_pipe_q[1]) begin
      rsp_id_d     = s1_id_q;
      rsp_color_d  = color;
      rsp_opaque_d = (color != 12'h000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      vld_pipe_q   <= '0;
      s1_id_q      <= '0;
      s1_bad_q     <= 1'b0;
      rsp_id_q     <= '0;
      rsp_color_q  <= '0;
      rsp_opaque_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      vld_pipe_q   <= vld_pipe_d;
      s1_id_q      <= s1_id_d;
      s1_bad_q     <= s1_bad_d;
      rsp_id_q     <= rsp_id_d;
      rsp_color_q  <= rsp_color_d;
      rsp_opaque_q <= rsp_opaque_d;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.rom_row    = rom_row;
  assign bus.rom_col    = rom_col;
  assign bus.rsp_valid  = vld_pipe_q[STAGES];
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_color  = rsp_color_q;
  assign bus.rsp_opaque = rsp_opaque_q;
endmodule

// File: tb/tb_fish_rom_arbiter.sv
// Bench for fish_rom_arbiter: owns the sprite ROM and a transaction-level
// round-robin model whose responses emerge two cycles after each grant.
module tb_fish_rom_arbiter;
  localparam int N  = 4;
  localparam int OW = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fish_rom_arbiter_if #(.N_REQ(N)) bus ();
  fish_rom_arbiter #(.N_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [11:0] rom [8][16];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_row][bus.rom_col];

  typedef struct {
    bit          v;
    int          id;
    logic [11:0] color;
  } rsp_t;

  rsp_t        m_cur, m_d1, m_d2;
  int          m_ptr;
  int          cyc, npass, ntotal;
  logic [N-1:0] e_gnt;
  logic [2:0]  e_row;
  logic [3:0]  e_col;

  function automatic logic [11:0] lookup(int row, int col);
    if (col == 15) return 12'h000;
    return rom[row][col];
  endfunction

  function automatic void model_reset();
    m_ptr = 0;
    m_cur = '{0, 0, 12'h0};
    m_d1  = '{0, 0, 12'h0};
    m_d2  = '{0, 0, 12'h0};
  endfunction

  function automatic void model_eval();
    int i;
    e_gnt = '0; e_row = '0; e_col = '0;
    m_cur = '{0, 0, 12'h0};
    if (rst_n && bus.en) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!m_cur.v && bus.req[i]) begin
          m_cur.v  = 1;
          m_cur.id = i;
          e_gnt[i] = 1'b1;
          e_row    = bus.req_row[3*i +: 3];
          e_col    = bus.req_col[4*i +: 4];
          m_cur.color = lookup(int'(e_row), int'(e_col));
        end
      end
    end
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    logic [14:0] r;
    r = m_d2.v ? {2'(m_d2.id), m_d2.color, (m_d2.color != 12'h0)} : 15'h0;
    return {e_gnt, e_row, e_col, 1'(m_d2.v), r};
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    logic [14:0] r;
    r = bus.rsp_valid ? {bus.rsp_id, bus.rsp_color, bus.rsp_opaque} : 15'h0;
    return {bus.gnt, bus.rom_row, bus.rom_col, bus.rsp_valid, r};
  endfunction

  task automatic advance();
    @(posedge clk);
    m_d2 = m_d1;
    m_d1 = m_cur;
    if (m_cur.v) m_ptr = (m_cur.id + 1) % N;
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.req = '0; bus.req_row = '0; bus.req_col = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.en = 1'b1; bus.req = '1;
    bus.req_row = '0; bus.req_col = '0;
    @(negedge clk);
    ntotal++;
    if ({bus.gnt, bus.rom_row, bus.rom_col, bus.rsp_valid} !== 12'h0)
      $display("FAIL reset_idle: got %h want 000", {bus.gnt, bus.rom_row, bus.rom_col, bus.rsp_valid});
    else npass++;
    do_reset();
    bus.en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.req = 4'b0001;
      bus.req_row[2:0] = 3'($urandom_range(0, 7));
      bus.req_col[3:0] = 4'($urandom_range(0, 14));
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_pre cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      advance();
    end
    bus.req = '0;
    #1; ntotal++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL reset_inflight: rsp_valid got %b want 1", bus.rsp_valid);
    else npass++;
    rst_n = 1'b0;
    #1; ntotal++;
    if ({bus.rsp_valid, bus.gnt} !== 5'b0) $display("FAIL reset_async: got %b want 00000", {bus.rsp_valid, bus.gnt});
    else npass++;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec() || bus.rsp_valid !== 1'b0 || bus.gnt !== 4'b0)
        $display("FAIL reset_after cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      advance();
    end
  endtask

  task automatic test_single();
    bus.en = 1'b1; bus.req = 4'b0100;
    bus.req_row = '0; bus.req_col = '0;
    bus.req_row[6 +: 3] = 3'd1;
    bus.req_col[8 +: 4] = 4'd4;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL single cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      if (t == 0) begin
        ntotal++;
        if ({bus.gnt, bus.rom_row, bus.rom_col} !== {4'b0100, 3'd1, 4'd4})
          $display("FAIL single_gnt: got %h want %h", {bus.gnt, bus.rom_row, bus.rom_col}, {4'b0100, 3'd1, 4'd4});
        else npass++;
      end
      if (t == 2) begin
        ntotal++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_color, bus.rsp_opaque} !== {1'b1, 2'd2, 12'hFC6, 1'b1})
          $display("FAIL single_rsp: got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_color, bus.rsp_opaque},
                   {1'b1, 2'd2, 12'hFC6, 1'b1});
        else npass++;
      end
      advance();
      if (t == 0) bus.req = '0;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.en = 1'b1; bus.req = '1;
    bus.req_row = 12'($urandom);
    bus.req_col = 16'($urandom) & 16'h7777;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL rr cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      if (t < 6) begin
        ntotal++;
        if (bus.gnt !== 4'(1 << (t % 4))) $display("FAIL rr_order t%0d: gnt got %b want %b", t, bus.gnt, 4'(1 << (t % 4)));
        else npass++;
      end
      if (t >= 2) begin
        ntotal++;
        if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'((t - 2) % 4)})
          $display("FAIL rr_rsp t%0d: got %b want %b", t, {bus.rsp_valid, bus.rsp_id}, {1'b1, 2'((t - 2) % 4)});
        else npass++;
      end
      advance();
    end
    bus.req = '0;
    repeat (2) begin @(negedge clk); model_eval(); advance(); end
  endtask

  task automatic test_colors();
    int          rr [4] = '{2, 4, 3, 0};
    int          cc [4] = '{3, 4, 12, 0};
    logic [11:0] ec [4] = '{12'hB7B, 12'h000, 12'hFC6, 12'h000};
    logic        eo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) begin
        bus.req = 4'b0001;
        bus.req_row[2:0] = 3'(rr[t]);
        bus.req_col[3:0] = 4'(cc[t]);
      end else bus.req = '0;
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL colors cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      if (t >= 2) begin
        ntotal++;
        if ({bus.rsp_valid, bus.rsp_color, bus.rsp_opaque} !== {1'b1, ec[t-2], eo[t-2]})
          $display("FAIL color_%0d: got %h want %h", t - 2, {bus.rsp_valid, bus.rsp_color, bus.rsp_opaque},
                   {1'b1, ec[t-2], eo[t-2]});
        else npass++;
      end
      advance();
    end
  endtask

  task automatic test_bad_col();
    bus.en = 1'b1; bus.req = 4'b0010;
    bus.req_row[5:3] = 3'd3;
    bus.req_col[7:4] = 4'd15;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL badcol cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      if (t == 0) begin
        ntotal++;
        if ({bus.gnt, bus.rom_col} !== {4'b0010, 4'd15}) $display("FAIL badcol_gnt: got %h want 2f", {bus.gnt, bus.rom_col});
        else npass++;
      end
      if (t == 2) begin
        ntotal++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_color, bus.rsp_opaque} !== {1'b1, 2'd1, 12'h000, 1'b0})
          $display("FAIL badcol_rsp: got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_color, bus.rsp_opaque},
                   {1'b1, 2'd1, 12'h000, 1'b0});
        else npass++;
      end
      advance();
      if (t == 0) bus.req = '0;
    end
  endtask

  task automatic test_en_toggle();
    int nrsp = 0;
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0010;
    bus.req_row = 12'($urandom);
    bus.req_col = 16'($urandom) & 16'h7777;
    for (int t = 0; t < 8; t++) begin
      if (t == 1) begin bus.req = '1; bus.en = 1'b0; end
      if (t == 4) bus.en = 1'b1;
      if (t == 5) bus.req = '0;
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL en cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      if (t >= 1 && t <= 3) begin
        if (bus.rsp_valid === 1'b1) nrsp++;
        ntotal++;
        if (bus.gnt !== 4'b0) $display("FAIL en_low_gnt t%0d: got %b want 0000", t, bus.gnt);
        else npass++;
      end
      if (t == 4) begin
        ntotal++;
        if (nrsp != 1) $display("FAIL en_low_rsp: got %0d responses want 1", nrsp);
        else npass++;
        ntotal++;
        if (bus.gnt !== 4'b0100) $display("FAIL en_resume: gnt got %b want 0100", bus.gnt);
        else npass++;
      end
      advance();
    end
  endtask

  task automatic test_random();
    bit pend [N];
    int wait_c [N];
    for (int i = 0; i < N; i++) begin pend[i] = 0; wait_c[i] = 0; end
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          bus.req_row[3*i +: 3] = 3'($urandom_range(0, 7));
          bus.req_col[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        bus.req[i] = pend[i];
      end
      bus.en = ($urandom_range(0, 4) != 0);
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL random cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && bus.gnt[i] === 1'b1) begin
          ntotal++;
          if (wait_c[i] > N - 1) $display("FAIL fairness req%0d: waited %0d want <= %0d", i, wait_c[i], N - 1);
          else npass++;
          pend[i] = 0;
          wait_c[i] = 0;
        end else if (pend[i] && bus.en) begin
          wait_c[i]++;
          if (wait_c[i] > N) begin
            ntotal++;
            $display("FAIL starved req%0d: waited %0d want <= %0d", i, wait_c[i], N - 1);
            wait_c[i] = 0;
          end
        end
      end
      advance();
    end
    bus.req = '0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); model_eval(); ntotal++;
      if (obs_vec() !== exp_vec()) $display("FAIL drain cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      else npass++;
      advance();
    end
  endtask

  initial begin
    npass = 0; ntotal = 0; cyc = 0;
    model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) rom[r][c] = 12'($urandom);
    rom[1][4]  = 12'hFC6;
    rom[2][3]  = 12'hB7B;
    rom[4][4]  = 12'h000;
    rom[3][12] = 12'hFC6;
    rom[0][0]  = 12'h000;
    for (int r = 0; r < 8; r++) rom[r][15] = 12'hABC;

    test_reset();
    test_single();
    test_round_robin();
    test_colors();
    test_bad_col();
    test_en_toggle();
    test_random();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
